// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use interlock, EX redirect flush,
// APB freeze with bounded wait, and debug event counters.
module pipe_hazard_ctrl #(
    parameter int APB_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_rs1_addr_id,
    input  logic [4:0]       i_rs2_addr_id,
    input  logic             i_rs1_used_id,
    input  logic             i_rs2_used_id,
    input  logic [4:0]       i_rd_addr_ex,
    input  logic             i_mem_read_ex,
    input  logic             i_branch_taken_ex,
    input  logic             i_jump_ex,
    input  logic             i_apb_req_mem,
    input  logic             i_apb_pready,
    input  logic             i_apb_pslverr,
    output logic             o_stall_pc,
    output logic             o_stall_ifid,
    output logic             o_stall_idex,
    output logic             o_stall_exmem,
    output logic             o_flush_ifid,
    output logic             o_flush_idex,
    output logic             o_bubble_memwb,
    output logic             o_control_hazard,
    output logic             o_apb_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int TCNT_W = (APB_TIMEOUT > 2) ? $clog2(APB_TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(APB_TIMEOUT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        APB_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [TCNT_W-1:0] tcnt;
    logic              lu;
    logic              redir;
    logic              apb_stall;
    logic              tcnt_last;
    logic              release_wait;
    logic              apb_err_next;

    always_comb begin
        lu = i_mem_read_ex && (i_rd_addr_ex != 5'd0) &&
             ((i_rs1_used_id && (i_rs1_addr_id == i_rd_addr_ex)) ||
              (i_rs2_used_id && (i_rs2_addr_id == i_rd_addr_ex)));
        redir     = i_branch_taken_ex | i_jump_ex;
        tcnt_last = (tcnt == TCNT_LAST);
    end

    // The release cycle itself is not frozen; a request seen then is re-sampled in RUN.
    always_comb begin
        next_state   = state;
        apb_stall    = 1'b0;
        release_wait = 1'b0;
        apb_err_next = 1'b0;
        case (state)
            RUN: begin
                apb_stall = i_apb_req_mem;
                if (i_apb_req_mem) begin
                    next_state = APB_WAIT;
                end
            end
            APB_WAIT: begin
                apb_stall    = ~i_apb_pready & ~tcnt_last;
                release_wait = i_apb_pready | tcnt_last;
                apb_err_next = (i_apb_pready & i_apb_pslverr) |
                               (~i_apb_pready & tcnt_last);
                if (release_wait) begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= RUN;
            tcnt        <= '0;
            o_apb_err   <= 1'b0;
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            state     <= next_state;
            o_apb_err <= apb_err_next;
            if (state == RUN) begin
                tcnt <= '0;
            end else if (!release_wait) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
            if (o_stall_pc) begin
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            end
            if (o_flush_idex) begin
                o_flush_cnt <= o_flush_cnt + CNT_W'(1);
            end
        end
    end

    // A frozen EX stage defers any redirect until the APB transfer releases.
    always_comb begin
        o_stall_pc       = 1'b0;
        o_stall_ifid     = 1'b0;
        o_stall_idex     = 1'b0;
        o_stall_exmem    = 1'b0;
        o_flush_ifid     = 1'b0;
        o_flush_idex     = 1'b0;
        o_bubble_memwb   = 1'b0;
        o_control_hazard = 1'b0;
        if (apb_stall) begin
            o_stall_pc     = 1'b1;
            o_stall_ifid   = 1'b1;
            o_stall_idex   = 1'b1;
            o_stall_exmem  = 1'b1;
            o_bubble_memwb = 1'b1;
        end else if (redir) begin
            o_control_hazard = 1'b1;
            o_flush_ifid     = 1'b1;
            o_flush_idex     = 1'b1;
        end else if (lu) begin
            o_stall_pc   = 1'b1;
            o_stall_ifid = 1'b1;
            o_flush_idex = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// responses, a negedge monitor pops and compares each cycle.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    // Control bundle order: stall_pc, stall_ifid, stall_idex, stall_exmem,
    // flush_ifid, flush_idex, bubble_memwb, control_hazard
    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_LU    = 8'b1100_0100;
    localparam logic [7:0] C_REDIR = 8'b0000_1101;
    localparam logic [7:0] C_APB   = 8'b1111_0010;

    typedef struct packed {
        logic       reset;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       bt;
        logic       jmp;
        logic       req;
        logic       pready;
        logic       pslverr;
    } stim_t;

    typedef struct {
        int             id;
        logic [7:0]     ctrl;
        logic           err;
        logic [CNT_W-1:0] scnt;
        logic [CNT_W-1:0] fcnt;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [4:0]       rs1_addr_id;
    logic [4:0]       rs2_addr_id;
    logic             rs1_used_id;
    logic             rs2_used_id;
    logic [4:0]       rd_addr_ex;
    logic             mem_read_ex;
    logic             branch_taken_ex;
    logic             jump_ex;
    logic             apb_req_mem;
    logic             apb_pready;
    logic             apb_pslverr;
    logic             stall_pc;
    logic             stall_ifid;
    logic             stall_idex;
    logic             stall_exmem;
    logic             flush_ifid;
    logic             flush_idex;
    logic             bubble_memwb;
    logic             control_hazard;
    logic             apb_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    stim_t            s;
    exp_t             sb[$];
    exp_t             e;
    int               vec_id;
    int               checks;
    int               errors;
    logic [CNT_W-1:0] model_scnt;
    logic [CNT_W-1:0] model_fcnt;

    pipe_hazard_ctrl #(.APB_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_rs1_addr_id     (rs1_addr_id),
        .i_rs2_addr_id     (rs2_addr_id),
        .i_rs1_used_id     (rs1_used_id),
        .i_rs2_used_id     (rs2_used_id),
        .i_rd_addr_ex      (rd_addr_ex),
        .i_mem_read_ex     (mem_read_ex),
        .i_branch_taken_ex (branch_taken_ex),
        .i_jump_ex         (jump_ex),
        .i_apb_req_mem     (apb_req_mem),
        .i_apb_pready      (apb_pready),
        .i_apb_pslverr     (apb_pslverr),
        .o_stall_pc        (stall_pc),
        .o_stall_ifid      (stall_ifid),
        .o_stall_idex      (stall_idex),
        .o_stall_exmem     (stall_exmem),
        .o_flush_ifid      (flush_ifid),
        .o_flush_idex      (flush_idex),
        .o_bubble_memwb    (bubble_memwb),
        .o_control_hazard  (control_hazard),
        .o_apb_err         (apb_err),
        .o_stall_cnt       (stall_cnt),
        .o_flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearStim();
        s = '0;
    endtask

    // Drives one cycle of stimulus and, when push is set, queues the
    // hand-computed response; counters advance from the expected flags.
    task automatic applyStimulus(input bit push, input logic [7:0] ctrl, input logic err);
        exp_t x;
        @(posedge clk);
        #1;
        reset           = s.reset;
        rs1_addr_id     = s.rs1;
        rs2_addr_id     = s.rs2;
        rs1_used_id     = s.u1;
        rs2_used_id     = s.u2;
        rd_addr_ex      = s.rd;
        mem_read_ex     = s.mr;
        branch_taken_ex = s.bt;
        jump_ex         = s.jmp;
        apb_req_mem     = s.req;
        apb_pready      = s.pready;
        apb_pslverr     = s.pslverr;
        if (push) begin
            x.id   = vec_id;
            x.ctrl = ctrl;
            x.err  = err;
            x.scnt = model_scnt;
            x.fcnt = model_fcnt;
            sb.push_back(x);
        end
        vec_id++;
        if (s.reset) begin
            model_scnt = '0;
            model_fcnt = '0;
        end else begin
            if (ctrl[7]) model_scnt = model_scnt + 1;
            if (ctrl[2]) model_fcnt = model_fcnt + 1;
        end
    endtask

    task automatic checkOutput(input exp_t x);
        logic [7:0] act;
        act = {stall_pc, stall_ifid, stall_idex, stall_exmem,
               flush_ifid, flush_idex, bubble_memwb, control_hazard};
        checks++;
        if (act !== x.ctrl) begin
            errors++;
            $display("[TB] FAIL ctrl vec%0d: got %b expected %b", x.id, act, x.ctrl);
        end
        checks++;
        if (apb_err !== x.err) begin
            errors++;
            $display("[TB] FAIL apb_err vec%0d: got %b expected %b", x.id, apb_err, x.err);
        end
        checks++;
        if (stall_cnt !== x.scnt || flush_cnt !== x.fcnt) begin
            errors++;
            $display("[TB] FAIL counters vec%0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     x.id, stall_cnt, flush_cnt, x.scnt, x.fcnt);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        vec_id     = 0;
        model_scnt = '0;
        model_fcnt = '0;
        clearStim();
        s.reset = 1'b1;
        applyStimulus(1'b0, C_NONE, 1'b0);
        applyStimulus(1'b0, C_NONE, 1'b0);

        $display("[TB] load-use and redirect vectors");
        clearStim();
        applyStimulus(1'b1, C_NONE, 1'b0);
        s.mr = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1;
        applyStimulus(1'b1, C_LU, 1'b0);
        clearStim();
        applyStimulus(1'b1, C_NONE, 1'b0);
        s.mr = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1;
        applyStimulus(1'b1, C_NONE, 1'b0);
        s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 0;
        applyStimulus(1'b1, C_NONE, 1'b0);
        s.rs1 = 5'd6; s.u1 = 1;
        applyStimulus(1'b1, C_NONE, 1'b0);
        s.rd = 5'd7; s.rs1 = 5'd3; s.rs2 = 5'd7; s.u2 = 1;
        applyStimulus(1'b1, C_LU, 1'b0);
        clearStim();
        s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1;
        applyStimulus(1'b1, C_NONE, 1'b0);
        s.mr = 1; s.bt = 1;
        applyStimulus(1'b1, C_REDIR, 1'b0);
        clearStim();
        s.jmp = 1;
        applyStimulus(1'b1, C_REDIR, 1'b0);

        $display("[TB] APB wait with PREADY at wait cycle 3 and pending branch");
        clearStim();
        s.req = 1; s.bt = 1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, C_APB, 1'b0);
        s.pready = 1;
        applyStimulus(1'b1, C_REDIR, 1'b0);
        clearStim();
        applyStimulus(1'b1, C_NONE, 1'b0);
        applyStimulus(1'b1, C_NONE, 1'b0);

        $display("[TB] APB timeout");
        s.req = 1;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, C_APB, 1'b0);
        applyStimulus(1'b1, C_NONE, 1'b0);
        clearStim();
        applyStimulus(1'b1, C_NONE, 1'b1);
        applyStimulus(1'b1, C_NONE, 1'b0);

        $display("[TB] APB slave error");
        s.req = 1;
        applyStimulus(1'b1, C_APB, 1'b0);
        s.pready = 1; s.pslverr = 1;
        applyStimulus(1'b1, C_NONE, 1'b0);
        clearStim();
        applyStimulus(1'b1, C_NONE, 1'b1);
        applyStimulus(1'b1, C_NONE, 1'b0);

        $display("[TB] reset during APB wait");
        s.req = 1;
        applyStimulus(1'b1, C_APB, 1'b0);
        applyStimulus(1'b1, C_APB, 1'b0);
        s.reset = 1;
        applyStimulus(1'b1, C_APB, 1'b0);
        clearStim();
        applyStimulus(1'b1, C_NONE, 1'b0);
        s.mr = 1; s.rd = 5'd9; s.rs2 = 5'd9; s.u2 = 1;
        applyStimulus(1'b1, C_LU, 1'b0);
        clearStim();
        applyStimulus(1'b1, C_NONE, 1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It detects load-use hazards between ID and EX and converts a resolved taken branch/jump in EX into IF/ID and ID/EX flushes plus the PC redirect. It freezes the pipeline while a MEM-stage APB transfer waits on PREADY, with a bounded timeout. It also keeps free-running stall and flush event counters for debug.

## Interface
- APB_TIMEOUT, 16: maximum APB_WAIT cycles before forced release (≥2).
- CNT_W, 32: width of event counters.

- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rs1_addr_id  in  5  rs1 index of instruction in ID.
- i_rs2_addr_id  in  5  rs2 index of instruction in ID.
- i_rs1_used_id  in  1  ID instruction reads rs1.
- i_rs2_used_id  in  1  ID instruction reads rs2.
- i_rd_addr_ex  in  5  destination of instruction in EX.
- i_mem_read_ex  in  1  EX instruction is a load.
- i_branch_taken_ex  in  1  branch decision taken in EX.
- i_jump_ex  in  1  JAL/JALR in EX.
- i_apb_req_mem  in  1  MEM instruction targets the APB region.
- i_apb_pready  in  1  APB PREADY.
- i_apb_pslverr  in  1  APB PSLVERR, sampled with PREADY.
- o_stall_pc  out  1  hold PC.
- o_stall_ifid  out  1  hold IF/ID register.
- o_stall_idex  out  1  hold ID/EX register.
- o_stall_exmem  out  1  hold EX/MEM register.
- o_flush_ifid  out  1  load NOP into IF/ID.
- o_flush_idex  out  1  load NOP into ID/EX.
- o_bubble_memwb  out  1  load NOP into MEM/WB.
- o_control_hazard  out  1  force pc_sel to the EX target.
- o_apb_err  out  1  one-cycle pulse after an errored or timed-out APB release.
- o_stall_cnt  out  CNT_W  cycles with o_stall_pc high.
- o_flush_cnt  out  CNT_W  cycles with o_flush_idex high.

## Operation
- FSM states: RUN and APB_WAIT. Reset state is RUN, with timeout counter 0, both event counters 0, and o_apb_err 0.
- Load-use: lu = i_mem_read_ex & (i_rd_addr_ex != 0) & ((i_rs1_used_id & rs1 match) | (i_rs2_used_id & rs2 match)).
- Redirect: redir = i_branch_taken_ex | i_jump_ex.
- Priority, highest first:
  - APB freeze (apb_stall): o_stall_pc, o_stall_ifid, o_stall_idex and o_stall_exmem are 1. o_bubble_memwb is 1. All flushes are 0. o_control_hazard is 0, so the redirect is deferred because EX is frozen.
  - redir: o_control_hazard=1, o_flush_ifid=1, o_flush_idex=1. No stalls. lu is ignored because the ID instruction is killed.
  - lu: o_stall_pc=1, o_stall_ifid=1, o_flush_idex=1 (one bubble).
  - Otherwise all outputs are 0.
- apb_stall in RUN is i_apb_req_mem (setup phase). The FSM moves to APB_WAIT and clears the timeout counter.
- apb_stall in APB_WAIT is ~i_apb_pready & (tcnt != APB_TIMEOUT-1).
- APB_WAIT releases when i_apb_pready=1 or when tcnt=APB_TIMEOUT-1. On release the FSM returns to RUN. Otherwise tcnt increments.
- o_apb_err is registered. It goes high the cycle after a release where (i_apb_pready & i_apb_pslverr) or a timeout occurred without PREADY.
- Counters increment by 1 on each qualifying cycle and wrap modulo 2^CNT_W.
- Reset during APB_WAIT returns the FSM to RUN. All stalls drop the following cycle.

## Timing
- All stall/flush/hazard outputs are combinational from the inputs and state; there is zero added latency.
- State, tcnt, o_apb_err and the counters update on the rising edge of i_clk.
- Load-use produces exactly 1 stall cycle. Redirect produces exactly 1 flush cycle; the EX instruction's successor pair is killed.
- APB access with PREADY at wait cycle k (k≥0) freezes for 1+k cycles.
- Timeout freezes for exactly APB_TIMEOUT cycles total, then releases regardless of PREADY.
- A new i_apb_req_mem in the release cycle is not a new request. The FSM returns to RUN and samples the request again next cycle.

## Test plan
- Load x5 in EX, ID reads rs1=x5 with used=1 → one cycle of o_stall_pc=o_stall_ifid=o_flush_idex=1. o_stall_cnt=1 and o_flush_cnt=1.
- Same load with rd=x0, or with i_rs1_used_id=0 → no stall.
- i_branch_taken_ex=1 together with a load-use → o_control_hazard=o_flush_ifid=o_flush_idex=1 and o_stall_pc=0.
- APB request, PREADY high on the 3rd wait cycle → stalls and o_bubble_memwb are high 4 cycles. A branch taken during that window gives o_control_hazard=0 until release, then 1. o_apb_err stays 0.
- APB request, PREADY never rises, APB_TIMEOUT=16 → freeze exactly 16 cycles, then o_apb_err pulses 1 cycle. The FSM returns to RUN.
- PSLVERR=1 with PREADY → o_apb_err pulses the next cycle. Mid-wait i_reset → all outputs 0 next cycle and counters cleared.
